baopoco_acc_ctrl: RTL and testbench

BAOPOCO_ACC_CTRL -- requirements
Module: baopoco_acc_ctrl

---
 rtl/baopoco_acc_ctrl_if.sv | 24 ++
 rtl/baopoco_acc_ctrl.sv | 85 ++++++++
 tb/tb_baopoco_acc_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/baopoco_acc_ctrl_if.sv
// Control/status bundle between the accumulation controller and its host logic.
interface baopoco_acc_ctrl_if #(
  parameter int unsigned C_CNT_W = 32
);
  logic               arm;
  logic               sync_in;
  logic               vec_valid;
  logic [C_CNT_W-1:0] acc_len;
  logic               acc_first;
  logic               acc_done;
  logic [31:0]        acc_num;
  logic               armed;
  logic               sync_err;

  modport master (
    output arm, sync_in, vec_valid, acc_len,
    input  acc_first, acc_done, acc_num, armed, sync_err
  );

  modport slave (
    input  arm, sync_in, vec_valid, acc_len,
    output acc_first, acc_done, acc_num, armed, sync_err
  );
endinterface

// File: rtl/baopoco_acc_ctrl.sv
// Accumulation controller: arms on a software edge, starts on F-engine sync,
// frames vectors into acc_len-long accumulations and counts completions.
module baopoco_acc_ctrl #(
  parameter int unsigned C_CNT_W = 32
) (
  input  logic                user_clk,
  input  logic                user_rst,
  baopoco_acc_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t             state_q, state_d;
  logic               arm_q;
  logic               arm_edge;
  logic [C_CNT_W-1:0] vec_cnt_q;
  logic [C_CNT_W-1:0] len_q;
  logic               pend_q;
  logic [31:0]        acc_num_q;
  logic               armed_q;
  logic               sync_err_q;
  logic               in_run;
  logic               last_vec;
  logic               start;

  assign arm_edge = bus.arm & ~arm_q;
  assign in_run   = (state_q == RUN);
  assign last_vec = (vec_cnt_q == len_q - C_CNT_W'(1));
  assign start    = (state_q == ARMED) & bus.sync_in;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm_edge)    state_d = ARMED;
      // Sync wins over a coincident arm edge while armed.
      ARMED:   if (bus.sync_in) state_d = RUN;
      RUN:     if (arm_edge)    state_d = ARMED;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      vec_cnt_q  <= '0;
      len_q      <= C_CNT_W'(1);
      pend_q     <= 1'b0;
      acc_num_q  <= '0;
      armed_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= bus.arm;
      armed_q <= (state_d == ARMED);
      if (start) begin
        len_q      <= (bus.acc_len == '0) ? C_CNT_W'(1) : bus.acc_len;
        vec_cnt_q  <= '0;
        acc_num_q  <= '0;
        sync_err_q <= 1'b0;
        pend_q     <= 1'b1;
      end else if (in_run) begin
        if (bus.sync_in && (vec_cnt_q != '0))
          sync_err_q <= 1'b1;
        if (bus.vec_valid) begin
          if (last_vec) begin
            vec_cnt_q <= '0;
            pend_q    <= 1'b1;
            acc_num_q <= acc_num_q + 32'd1;
          end else begin
            vec_cnt_q <= vec_cnt_q + C_CNT_W'(1);
            pend_q    <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.acc_first = bus.vec_valid & in_run & pend_q;
  assign bus.acc_done  = bus.vec_valid & in_run & last_vec;
  assign bus.acc_num   = acc_num_q;
  assign bus.armed     = armed_q;
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_baopoco_acc_ctrl.sv
// Scoreboard bench for baopoco_acc_ctrl: directed stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_baopoco_acc_ctrl;

  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  logic chk      = 1'b0;
  logic stim_done = 1'b0;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [1:0]  vq[$];   // {acc_first, acc_done}
  logic [33:0] sq[$];   // {acc_num, armed, sync_err}

  always #5 user_clk = ~user_clk;

  baopoco_acc_ctrl_if #(.C_CNT_W(32)) bif ();

  baopoco_acc_ctrl #(.C_CNT_W(32)) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .bus      (bif.slave)
  );

  always @(negedge user_clk) begin
    logic [1:0]  ev;
    logic [33:0] es;
    if (bif.vec_valid) begin
      n_total++;
      if (vq.size() == 0) begin
        $display("FAIL vec_underflow: got first=%0b done=%0b, no expectation queued",
                 bif.acc_first, bif.acc_done);
      end else begin
        ev = vq.pop_front();
        if ({bif.acc_first, bif.acc_done} === ev) n_pass++;
        else $display("FAIL vec t=%0t: first/done got %0b%0b want %0b%0b",
                      $time, bif.acc_first, bif.acc_done, ev[1], ev[0]);
      end
    end
    if (chk) begin
      n_total++;
      if (sq.size() == 0) begin
        $display("FAIL status_underflow: no expectation queued");
      end else begin
        es = sq.pop_front();
        if ({bif.acc_num, bif.armed, bif.sync_err} === es) n_pass++;
        else $display("FAIL status t=%0t: num=%0h armed=%0b err=%0b want num=%0h armed=%0b err=%0b",
                      $time, bif.acc_num, bif.armed, bif.sync_err, es[33:2], es[1], es[0]);
      end
    end
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
    bif.sync_in   = 1'b0;
    bif.vec_valid = 1'b0;
    chk           = 1'b0;
  endtask

  task automatic vec(input logic f, input logic d);
    bif.vec_valid = 1'b1;
    vq.push_back({f, d});
    tick();
  endtask

  task automatic sync();
    bif.sync_in = 1'b1;
    tick();
  endtask

  task automatic arm_edge();
    bif.arm = 1'b0;
    tick();
    bif.arm = 1'b1;
    tick();
  endtask

  task automatic status(input logic [31:0] num, input logic a, input logic e);
    sq.push_back({num, a, e});
    chk = 1'b1;
    tick();
  endtask

  initial begin
    bif.arm       = 1'b0;
    bif.sync_in   = 1'b0;
    bif.vec_valid = 1'b0;
    bif.acc_len   = 32'd4;
    repeat (2) @(posedge user_clk);
    #1;
    status(32'd0, 1'b0, 1'b0);
    user_rst = 1'b0;
    tick();

    // reset state and IDLE ignores vectors
    status(32'd0, 1'b0, 1'b0);
    vec(1'b0, 1'b0);

    // acc_len=4 over 12 vectors
    arm_edge();
    status(32'd0, 1'b1, 1'b0);
    vec(1'b0, 1'b0);                  // ARMED ignores vectors
    sync();
    for (int i = 1; i <= 12; i++)
      vec((i % 4) == 1, (i % 4) == 0);
    status(32'd3, 1'b0, 1'b0);
    sync();                           // vec_cnt==0: ignored
    status(32'd3, 1'b0, 1'b0);

    // acc_len=0 behaves as 1
    bif.acc_len = 32'd0;
    arm_edge();
    sync();
    for (int i = 0; i < 3; i++) vec(1'b1, 1'b1);
    status(32'd3, 1'b0, 1'b0);

    // mid-accumulation sync flags an error but does not realign
    bif.acc_len = 32'd8;
    arm_edge();
    sync();
    vec(1'b1, 1'b0);
    vec(1'b0, 1'b0);
    vec(1'b0, 1'b0);
    sync();
    status(32'd0, 1'b0, 1'b1);
    bif.acc_len = 32'd2;              // no effect until the next start
    for (int i = 4; i <= 7; i++) vec(1'b0, 1'b0);
    vec(1'b0, 1'b1);
    status(32'd1, 1'b0, 1'b1);

    // re-arm mid-accumulation abandons it
    vec(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) vec(1'b0, 1'b0);
    bif.acc_len = 32'd4;
    arm_edge();
    status(32'd1, 1'b1, 1'b1);
    vec(1'b0, 1'b0);
    sync();
    status(32'd0, 1'b0, 1'b0);
    vec(1'b1, 1'b0);
    vec(1'b0, 1'b0);
    vec(1'b0, 1'b0);
    vec(1'b0, 1'b1);
    status(32'd1, 1'b0, 1'b0);

    // reset mid-run with acc_num=7
    bif.acc_len = 32'd1;
    arm_edge();
    sync();
    for (int i = 0; i < 7; i++) vec(1'b1, 1'b1);
    status(32'd7, 1'b0, 1'b0);
    bif.acc_len = 32'd3;
    sync();                            // no vectors: keep vec_cnt at 0
    bif.arm = 1'b0;
    tick();
    user_rst = 1'b1;
    #1;
    sq.push_back({32'd0, 1'b0, 1'b0});
    vq.push_back(2'b00);
    chk = 1'b1;
    bif.vec_valid = 1'b1;
    tick();
    user_rst = 1'b0;
    vec(1'b0, 1'b0);
    bif.sync_in = 1'b1;
    vec(1'b0, 1'b0);
    status(32'd0, 1'b0, 1'b0);
    arm_edge();
    sync();
    vec(1'b1, 1'b0);
    vec(1'b0, 1'b0);
    vec(1'b0, 1'b1);
    status(32'd1, 1'b0, 1'b0);

    // acc_num wrap from all-ones
    bif.acc_len = 32'd1;
    arm_edge();
    sync();
    vec(1'b1, 1'b1);
    status(32'd1, 1'b0, 1'b0);
    force dut.acc_num_q = 32'hFFFF_FFFF;
    #2;
    release dut.acc_num_q;
    tick();
    vec(1'b1, 1'b1);
    status(32'd0, 1'b0, 1'b0);

    tick();
    stim_done = 1'b1;
  end

  initial begin
    int unsigned guard;
    guard = 0;
    while (!stim_done && guard < 5000) begin
      @(posedge user_clk);
      guard++;
    end
    if (!stim_done) begin
      n_total++;
      $display("FAIL timeout: stimulus not done after %0d cycles, want done", guard);
    end
    repeat (4) @(posedge user_clk);
    if (vq.size() != 0 || sq.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d vec and %0d status expectations left, want 0",
               vq.size(), sq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
